// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bundle for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built from two half adders and a carry flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             c;
  logic             c_next;
  logic             s_bit;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [1:0]       ha0;
  logic [1:0]       ha1;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_adder(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  assign last = (cnt == CW'(WIDTH - 1));

  // Full-adder step from two half adders plus an OR; new sum bit enters the result MSB.
  always_comb begin
    ha0    = half_adder(sa[0], sb[0]);
    ha1    = half_adder(ha0[0], c);
    s_bit  = ha1[0];
    c_next = ha0[1] | ha1[1];
    r_next = (r >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  end

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH steps, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-step shifting, and result commit on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      r      <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            r   <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          r   <= r_next;
          c   <= c_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum_q  <= r_next;
            cout_q <= c_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [W-1:0] last_sum;
  logic         last_cout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passes++;
    end
  endtask

  // One operation: drive start with x/y, then step edge by edge checking the handshake timeline.
  // hold keeps start high and presents nx/ny for the following operation; poke pulses start mid-run.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold,
                        input logic [W-1:0] nx, input logic [W-1:0] ny, input bit poke);
    logic [W:0] expv;
    expv = {1'b0, x} + {1'b0, y};
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk); #1;
    bus.start = hold;
    bus.a = hold ? nx : W'($urandom);
    bus.b = hold ? ny : W'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("done_after_accept", 32'(bus.done), 32'd0);
    for (int i = 1; i < W; i++) begin
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.a = ~x;
        bus.b = y + W'(1);
      end
      if (poke && i == 3) bus.start = 1'b0;
      @(posedge clk); #1;
      check("busy_in_shift", 32'(bus.busy), 32'd1);
      check("done_in_shift", 32'(bus.done), 32'd0);
      check("sum_hold", 32'(bus.sum), 32'(last_sum));
      check("cout_hold", 32'(bus.cout), 32'(last_cout));
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("sum", 32'(bus.sum), 32'(expv[W-1:0]));
    check("cout", 32'(bus.cout), 32'(expv[W]));
    last_sum  = expv[W-1:0];
    last_cout = expv[W];
    @(posedge clk); #1;
    check("done_low_after", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    if (poke) begin
      @(posedge clk); #1;
      check("no_second_done", 32'(bus.done), 32'd0);
      check("no_second_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] cx, cy, nx, ny;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    last_sum = '0;
    last_cout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;

    // Directed cases; the first start is accepted on the first edge after reset release.
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0);
    run_op(8'h3C, 8'h99, 1'b0, 8'h00, 8'h00, 1'b1);

    // Abort four cycles into an operation with an asynchronous reset between edges.
    bus.start = 1'b1;
    bus.a = 8'h37;
    bus.b = 8'h55;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_sum = '0;
    last_cout = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(bus.done), 32'd0);
      check("abort_idle", 32'(bus.busy), 32'd0);
    end
    run_op(8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0);

    // Start held high: back-to-back accepts every W+2 edges over random operand pairs.
    cx = W'($urandom);
    cy = W'($urandom);
    for (int i = 0; i < 1000; i++) begin
      nx = W'($urandom);
      ny = W'($urandom);
      run_op(cx, cy, (i != 999), nx, ny, 1'b0);
      cx = nx;
      cy = ny;
    end
    bus.start = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
